// File: rtl/dtree_seq_engine.sv
// Sequential decision-tree classifier: a loadable node table walked one node per clock
// over a captured feature vector, with per-node comparison precision.
module dtree_seq_engine #(
    parameter int NUM_FEAT  = 5,
    parameter int FEAT_W    = 8,
    parameter int NUM_NODES = 16,
    parameter int DEPTH_MAX = 8,
    parameter int CLASS_W   = 6,
    localparam int FIDX_W   = $clog2(NUM_FEAT),
    localparam int PREC_W   = $clog2(FEAT_W),
    localparam int NODE_W   = $clog2(NUM_NODES),
    localparam int DEP_W    = $clog2(DEPTH_MAX + 1),
    localparam int CFG_W    = 1 + FIDX_W + PREC_W + FEAT_W + 2 * NODE_W + CLASS_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_we,
    input  logic [NODE_W-1:0]          cfg_addr,
    input  logic [CFG_W-1:0]           cfg_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_FEAT*FEAT_W-1:0] in_feat,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CLASS_W-1:0]         out_class,
    output logic [DEP_W-1:0]           out_depth,
    output logic                       out_err
);

    localparam logic [FIDX_W:0]   NF_L   = (FIDX_W + 1)'(NUM_FEAT);
    localparam logic [NODE_W:0]   NN_L   = (NODE_W + 1)'(NUM_NODES);
    localparam logic [DEP_W-1:0]  DMAX_L = DEP_W'(DEPTH_MAX);
    localparam logic [PREC_W-1:0] PMAX_L = PREC_W'(FEAT_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WALK = 2'd1,
        S_FIN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                      state_r;
    logic [CFG_W-1:0]            node_r [NUM_NODES];
    logic [NUM_FEAT*FEAT_W-1:0]  feat_r;
    logic [NODE_W-1:0]           ptr_r;
    logic [DEP_W-1:0]            depth_r;

    logic [CFG_W-1:0]            node_s;
    logic                        leaf_s;
    logic [FIDX_W-1:0]           fidx_s;
    logic [PREC_W-1:0]           prec_s;
    logic [FEAT_W-1:0]           thr_s;
    logic [NODE_W-1:0]           left_s;
    logic [NODE_W-1:0]           right_s;
    logic [CLASS_W-1:0]          cls_s;
    logic [FEAT_W-1:0]           feat_sel_s;
    logic [PREC_W-1:0]           shamt_s;
    logic [FEAT_W-1:0]           v_s;
    logic [NODE_W-1:0]           child_s;
    logic                        bad_s;

    // Current node lookup; an unmapped pointer reads as an all-zero node
    always_comb begin
        node_s = {CFG_W{1'b0}};
        for (int i = 0; i < NUM_NODES; i++) begin
            if (ptr_r == NODE_W'(i)) begin
                node_s = node_r[i];
            end else begin
                node_s = node_s;
            end
        end
    end

    assign leaf_s  = node_s[CFG_W-1];
    assign fidx_s  = node_s[CFG_W-2 -: FIDX_W];
    assign prec_s  = node_s[CFG_W-2-FIDX_W -: PREC_W];
    assign thr_s   = node_s[2*NODE_W+CLASS_W +: FEAT_W];
    assign left_s  = node_s[NODE_W+CLASS_W +: NODE_W];
    assign right_s = node_s[CLASS_W +: NODE_W];
    assign cls_s   = node_s[CLASS_W-1:0];

    // Feature select, precision truncation and branch decision for the current node
    always_comb begin
        feat_sel_s = {FEAT_W{1'b0}};
        for (int k = 0; k < NUM_FEAT; k++) begin
            if (fidx_s == FIDX_W'(k)) begin
                feat_sel_s = feat_r[k*FEAT_W +: FEAT_W];
            end else begin
                feat_sel_s = feat_sel_s;
            end
        end
        // Keeping the top prec+1 bits is a right shift by FEAT_W-1-prec
        if (prec_s >= PMAX_L) begin
            shamt_s = {PREC_W{1'b0}};
        end else begin
            shamt_s = PMAX_L - prec_s;
        end
        v_s = feat_sel_s >> shamt_s;
        if (v_s <= thr_s) begin
            child_s = left_s;
        end else begin
            child_s = right_s;
        end
        bad_s = ({1'b0, fidx_s} >= NF_L) || ({1'b0, child_s} >= NN_L);
    end

    // Control FSM, node table and registered result outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            feat_r    <= {(NUM_FEAT*FEAT_W){1'b0}};
            ptr_r     <= {NODE_W{1'b0}};
            depth_r   <= {DEP_W{1'b0}};
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_class <= {CLASS_W{1'b0}};
            out_depth <= {DEP_W{1'b0}};
            out_err   <= 1'b0;
            for (int i = 0; i < NUM_NODES; i++) begin
                node_r[i] <= {CFG_W{1'b0}};
            end
        end else begin
            case (state_r)
                S_IDLE: begin
                    for (int i = 0; i < NUM_NODES; i++) begin
                        if (cfg_we && (cfg_addr == NODE_W'(i))) begin
                            node_r[i] <= cfg_data;
                        end else begin
                            node_r[i] <= node_r[i];
                        end
                    end
                    if (in_valid) begin
                        feat_r   <= in_feat;
                        ptr_r    <= {NODE_W{1'b0}};
                        depth_r  <= {DEP_W{1'b0}};
                        in_ready <= 1'b0;
                        state_r  <= S_WALK;
                    end else begin
                        state_r  <= S_IDLE;
                    end
                end
                S_WALK: begin
                    if (leaf_s) begin
                        out_class <= cls_s;
                        out_depth <= depth_r;
                        out_err   <= 1'b0;
                        state_r   <= S_FIN;
                    end else if (bad_s) begin
                        out_class <= {CLASS_W{1'b0}};
                        out_depth <= depth_r;
                        out_err   <= 1'b1;
                        state_r   <= S_FIN;
                    end else if (depth_r == DMAX_L) begin
                        out_class <= {CLASS_W{1'b0}};
                        out_depth <= DMAX_L;
                        out_err   <= 1'b1;
                        state_r   <= S_FIN;
                    end else begin
                        ptr_r     <= child_s;
                        depth_r   <= depth_r + DEP_W'(1);
                        state_r   <= S_WALK;
                    end
                end
                S_FIN: begin
                    out_valid <= 1'b1;
                    state_r   <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_r   <= S_IDLE;
                    end else begin
                        state_r   <= S_DONE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state_r   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dtree_seq_engine.sv
// Scoreboard bench for dtree_seq_engine: directed vectors push expected results,
// a monitor checks each result handshake and its latency.
module tb_dtree_seq_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we, in_valid, in_ready, out_valid, out_ready, out_err;
    logic [3:0]  cfg_addr, out_depth;
    logic [28:0] cfg_data;
    logic [39:0] in_feat;
    logic [5:0]  out_class;

    logic        cfg_we2, in_valid2, in_ready2, out_valid2, out_err2;
    logic [3:0]  cfg_addr2, out_depth2;
    logic [28:0] cfg_data2;
    logic [39:0] in_feat2;
    logic [5:0]  out_class2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [5:0] c;
        logic [3:0] d;
        logic       e;
        time        t;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    dtree_seq_engine u_dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_feat(in_feat),
        .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
        .out_depth(out_depth), .out_err(out_err)
    );

    // Smaller table so an out-of-range child index is encodable
    dtree_seq_engine #(.NUM_NODES(12)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we2), .cfg_addr(cfg_addr2), .cfg_data(cfg_data2),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_feat(in_feat2),
        .out_valid(out_valid2), .out_ready(1'b1), .out_class(out_class2),
        .out_depth(out_depth2), .out_err(out_err2)
    );

    function automatic logic [28:0] mk(input logic leaf, input logic [2:0] f, input logic [2:0] p,
                                       input logic [7:0] thr, input logic [3:0] l, input logic [3:0] r,
                                       input logic [5:0] c);
        return {leaf, f, p, thr, l, r, c};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic cfg(input logic [3:0] a, input logic [28:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic send(input logic [39:0] f, input logic [5:0] c, input logic [3:0] d,
                        input logic e, input bit expect_out);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 32'd0, 32'd1);
        end else begin
            in_valid = 1'b1; in_feat = f;
            @(posedge clk);
            if (expect_out) q.push_back('{c: c, d: d, e: e, t: $time + (2 + d) * 10});
            @(negedge clk);
            in_valid = 1'b0; in_feat = 40'hA5_5A_C3_3C_FF;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
    endtask

    // Monitor: latency on every rising out_valid, contents on every handshake
    initial begin
        logic prev_v = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (out_valid && !prev_v) begin
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    chk("latency", 32'($time - 6), 32'(q[0].t));
                end
            end
            if (out_valid && out_ready && q.size() != 0) begin
                e = q.pop_front();
                chk("out_class", 32'(out_class), 32'(e.c));
                chk("out_depth", 32'(out_depth), 32'(e.d));
                chk("out_err",   32'(out_err),   32'(e.e));
            end
            prev_v = out_valid;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = 4'd0; cfg_data = 29'd0;
        in_valid = 1'b0; in_feat = 40'd0; out_ready = 1'b1;
        cfg_we2 = 1'b0; cfg_addr2 = 4'd0; cfg_data2 = 29'd0; in_valid2 = 1'b0; in_feat2 = 40'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_class", 32'(out_class), 32'd0);
        chk("rst_out_depth", 32'(out_depth), 32'd0);
        chk("rst_out_err",   32'(out_err),   32'd0);

        // Empty table: node 0 loops until the depth limit
        send(40'h12_34_56_78_9A, 6'd0, 4'd8, 1'b1, 1'b1);
        drain();

        // Two-leaf tree on feature 4, 4-bit precision
        cfg(4'd0, mk(1'b0, 3'd4, 3'd3, 8'd7, 4'd1, 4'd2, 6'd0));
        cfg(4'd1, mk(1'b1, 3'd0, 3'd0, 8'd0, 4'd0, 4'd0, 6'd43));
        cfg(4'd2, mk(1'b1, 3'd0, 3'd0, 8'd0, 4'd0, 4'd0, 6'd44));
        send(40'h70_00_00_00_00, 6'd43, 4'd1, 1'b0, 1'b1);
        send(40'h80_00_00_00_00, 6'd44, 4'd1, 1'b0, 1'b1);
        drain();

        // Table write during WALK is dropped, in IDLE it lands
        send(40'h80_00_00_00_00, 6'd44, 4'd1, 1'b0, 1'b1);
        cfg(4'd2, mk(1'b1, 3'd0, 3'd0, 8'd0, 4'd0, 4'd0, 6'd9));
        drain();
        cfg(4'd2, mk(1'b1, 3'd0, 3'd0, 8'd0, 4'd0, 4'd0, 6'd9));
        send(40'h80_00_00_00_00, 6'd9, 4'd1, 1'b0, 1'b1);
        drain();

        // Three-level tree
        cfg(4'd0, mk(1'b0, 3'd0, 3'd3, 8'd5, 4'd1, 4'd2, 6'd0));
        cfg(4'd1, mk(1'b0, 3'd4, 3'd1, 8'd1, 4'd3, 4'd4, 6'd0));
        cfg(4'd2, mk(1'b1, 3'd0, 3'd0, 8'd0, 4'd0, 4'd0, 6'd2));
        cfg(4'd3, mk(1'b1, 3'd0, 3'd0, 8'd0, 4'd0, 4'd0, 6'd3));
        cfg(4'd4, mk(1'b1, 3'd0, 3'd0, 8'd0, 4'd0, 4'd0, 6'd6));
        send(40'h40_00_00_00_50, 6'd3, 4'd2, 1'b0, 1'b1);
        send(40'h40_00_00_00_60, 6'd2, 4'd1, 1'b0, 1'b1);
        send(40'h80_00_00_00_50, 6'd6, 4'd2, 1'b0, 1'b1);
        drain();

        // Backpressure: result held, input refused, then one handshake
        out_ready = 1'b0;
        send(40'h40_00_00_00_50, 6'd3, 4'd2, 1'b0, 1'b1);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid_seen", 32'(out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_feat = 40'h80_00_00_00_60;
            chk("bp_valid_hold", 32'(out_valid), 32'd1);
            chk("bp_class_hold", 32'(out_class), 32'd3);
            chk("bp_in_ready",   32'(in_ready),  32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_ready", 32'(in_ready),  32'd1);
        drain();

        // Feature index beyond the vector
        cfg(4'd0, mk(1'b0, 3'd6, 3'd0, 8'd0, 4'd1, 4'd2, 6'd0));
        send(40'hFF_FF_FF_FF_FF, 6'd0, 4'd0, 1'b1, 1'b1);
        drain();

        // Reset mid-walk drops the inference and clears the table
        cfg(4'd0, mk(1'b0, 3'd0, 3'd3, 8'd5, 4'd1, 4'd2, 6'd0));
        send(40'h40_00_00_00_50, 6'd0, 4'd0, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        send(40'h40_00_00_00_50, 6'd0, 4'd8, 1'b1, 1'b1);
        drain();

        // Out-of-range child on the 12-node instance; write and accept in the same cycle
        @(negedge clk);
        cfg_we2 = 1'b1; cfg_addr2 = 4'd0; cfg_data2 = mk(1'b0, 3'd0, 3'd7, 8'h10, 4'd1, 4'd13, 6'd5);
        in_valid2 = 1'b1; in_feat2 = 40'h00_00_00_00_FF;
        @(negedge clk);
        cfg_we2 = 1'b0; in_valid2 = 1'b0;
        n = 0;
        while (!out_valid2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("child_err_valid", 32'(out_valid2), 32'd1);
        chk("child_err_err",   32'(out_err2),   32'd1);
        chk("child_err_depth", 32'(out_depth2), 32'd0);
        chk("child_err_class", 32'(out_class2), 32'd0);

        repeat (5) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
